// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, reads 16-bit words over a req/ack port
// and hands each word to decode through a one-entry valid/ready buffer.
module fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [15:0] inst,
  output logic [15:0] inst_pc,
  output logic [15:0] inst_pc_plus2,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic        halted,
  output logic [2:0]  dbg_state_o
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_FLUSH  = 3'd2,
    S_DRAIN  = 3'd3,
    S_HALTED = 3'd4
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] inst_q, inst_d;
  logic [15:0] inst_pc_q, inst_pc_d;
  logic        valid_q, valid_d;
  logic [15:0] target;
  logic        handshake;

  // Memory side: imem_req/imem_addr hold until imem_ack; an ack with no request
  // is ignored. Decode side: a word moves when inst_valid & inst_ready.
  assign target    = redirect_pc & 16'hFFFE;
  assign handshake = valid_q & inst_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      pc_q      <= RESET_PC;
      addr_q    <= RESET_PC;
      inst_q    <= 16'h0000;
      inst_pc_q <= 16'h0000;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      addr_q    <= addr_d;
      inst_q    <= inst_d;
      inst_pc_q <= inst_pc_d;
      valid_q   <= valid_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    addr_d    = addr_q;
    inst_d    = inst_q;
    inst_pc_d = inst_pc_q;
    valid_d   = valid_q;
    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        if (redirect) begin
          pc_d    = target;
          valid_d = 1'b0;
          // Without an ack the old read is still in flight; remember its address.
          if (!imem_ack) begin
            addr_d  = pc_q;
            state_d = S_FLUSH;
          end
        end else if (imem_ack) begin
          inst_d    = imem_data;
          inst_pc_d = pc_q;
          valid_d   = 1'b1;
          pc_d      = pc_q + 16'd2;
          state_d   = S_DRAIN;
        end
      end
      S_FLUSH: begin
        if (redirect) begin
          pc_d    = target;
          valid_d = 1'b0;
        end
        if (imem_ack) state_d = S_FETCH;
      end
      S_DRAIN: begin
        if (redirect) begin
          pc_d    = target;
          valid_d = 1'b0;
          state_d = S_FETCH;
        end else if (handshake) begin
          valid_d = 1'b0;
          state_d = (inst_q[15:12] == 4'hF) ? S_HALTED : S_FETCH;
        end
      end
      S_HALTED: valid_d = 1'b0;
      default:  state_d = S_IDLE;
    endcase
  end

  assign imem_req      = (state_q == S_FETCH) || (state_q == S_FLUSH);
  assign imem_addr     = (state_q == S_FLUSH) ? addr_q : pc_q;
  assign inst_valid    = valid_q;
  assign inst          = inst_q;
  assign inst_pc       = inst_pc_q;
  assign inst_pc_plus2 = inst_pc_q + 16'd2;
  assign halted        = (state_q == S_HALTED);
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: programmable-latency memory, a transaction-level
// model of PC/buffer/outstanding-read behaviour, and per-cycle output comparison.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [15:0] imem_data = 16'h0000;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [15:0] inst;
  logic [15:0] inst_pc;
  logic [15:0] inst_pc_plus2;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = 16'h0000;
  logic        halted;
  logic [2:0]  dbg_state;

  int errors = 0;
  int checks = 0;

  fetch_unit #(.RESET_PC(16'h0000)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_data(imem_data),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst(inst), .inst_pc(inst_pc), .inst_pc_plus2(inst_pc_plus2),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .halted(halted), .dbg_state_o(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- memory ----------------
  logic [15:0] mem [logic [15:0]];
  int          lat = 0;
  logic        spur = 1'b0;
  int          cnt = 0;

  function automatic logic [15:0] word_at(input logic [15:0] a);
    if (mem.exists(a)) return mem[a];
    return {4'h1, a[11:0]};
  endfunction

  always @(negedge clk) begin
    if (!imem_req) begin
      imem_ack  = spur;
      imem_data = 16'hDEAD;
      cnt       = 0;
    end else if (cnt >= lat) begin
      imem_ack  = 1'b1;
      imem_data = word_at(imem_addr);
      cnt       = 0;
    end else begin
      imem_ack  = 1'b0;
      cnt       = cnt + 1;
    end
  end

  // ---------------- model ----------------
  logic        m_started, m_req, m_stale, m_buf_v, m_halted;
  logic [15:0] m_req_addr, m_pc, m_buf_inst, m_buf_pc;

  always @(posedge clk or negedge rst_n) begin : model
    logic        started, req, stale, buf_v, hlt, acked, consumed;
    logic [15:0] req_addr, pc, buf_inst, buf_pc;
    if (!rst_n) begin
      m_started <= 1'b0; m_req <= 1'b0; m_stale <= 1'b0; m_buf_v <= 1'b0;
      m_halted <= 1'b0; m_req_addr <= 16'h0000; m_pc <= 16'h0000;
      m_buf_inst <= 16'h0000; m_buf_pc <= 16'h0000;
    end else begin
      started = m_started; req = m_req; stale = m_stale; buf_v = m_buf_v;
      hlt = m_halted; req_addr = m_req_addr; pc = m_pc;
      buf_inst = m_buf_inst; buf_pc = m_buf_pc;
      if (!started) begin
        started = 1'b1; req = 1'b1; req_addr = pc; stale = 1'b0;
      end else if (!hlt) begin
        acked    = req && imem_ack;
        consumed = buf_v && inst_ready;
        if (redirect) begin
          pc    = redirect_pc & 16'hFFFE;
          buf_v = 1'b0;
          if (req && !acked) stale = 1'b1;
          else begin req = 1'b1; req_addr = pc; stale = 1'b0; end
        end else begin
          if (acked) begin
            if (stale) begin req = 1'b1; req_addr = pc; stale = 1'b0; end
            else begin
              buf_v = 1'b1; buf_inst = imem_data; buf_pc = pc;
              pc = pc + 16'd2; req = 1'b0;
            end
          end
          if (consumed) begin
            buf_v = 1'b0;
            if (buf_inst[15:12] == 4'hF) begin hlt = 1'b1; req = 1'b0; end
            else begin req = 1'b1; req_addr = pc; stale = 1'b0; end
          end
        end
      end
      m_started <= started; m_req <= req; m_stale <= stale; m_buf_v <= buf_v;
      m_halted <= hlt; m_req_addr <= req_addr; m_pc <= pc;
      m_buf_inst <= buf_inst; m_buf_pc <= buf_pc;
    end
  end

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic note_timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting at %0t", name, $time);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      chk("m_req", {15'd0, imem_req}, {15'd0, m_req});
      if (m_req) chk("m_addr", imem_addr, m_req_addr);
      chk("m_valid", {15'd0, inst_valid}, {15'd0, m_buf_v});
      if (m_buf_v) begin
        chk("m_inst", inst, m_buf_inst);
        chk("m_inst_pc", inst_pc, m_buf_pc);
        chk("m_pc_plus2", inst_pc_plus2, m_buf_pc + 16'd2);
      end
      chk("m_halted", {15'd0, halted}, {15'd0, m_halted});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset(input int latency, input logic rdy);
    @(negedge clk);
    rst_n      = 1'b0;
    redirect   = 1'b0;
    inst_ready = rdy;
    lat        = latency;
    mem.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_valid(input int max_cyc, output int n);
    n = 0;
    while (!inst_valid && n < max_cyc) begin @(negedge clk); n++; end
    if (!inst_valid) note_timeout("wait_valid");
  endtask

  task automatic wait_valid_pc(input logic [15:0] pc, input int max_cyc);
    int n = 0;
    while (!(inst_valid && inst_pc == pc) && n < max_cyc) begin @(negedge clk); n++; end
    if (!(inst_valid && inst_pc == pc)) note_timeout("wait_valid_pc");
  endtask

  task automatic wait_req(input int max_cyc);
    int n = 0;
    while (!imem_req && n < max_cyc) begin @(negedge clk); n++; end
    if (!imem_req) note_timeout("wait_req");
  endtask

  // ---------------- directed tests ----------------
  initial begin : stim
    int n, n2, reqs;

    // Reset values and zero-wait back-to-back fetch.
    do_reset(0, 1'b1);
    mem[16'h0000] = 16'h1234;
    mem[16'h0002] = 16'h5678;
    chk("rst_req_at_release", {15'd0, imem_req}, 16'h0000);
    wait_valid(20, n);
    chk("first_latency", n[15:0], 16'd2);
    chk("t1_inst0", inst, 16'h1234);
    chk("t1_pc0", inst_pc, 16'h0000);
    chk("t1_plus2_0", inst_pc_plus2, 16'h0002);
    @(negedge clk);
    wait_valid(20, n2);
    chk("t1_spacing", 16'(n2 + 1), 16'd2);
    chk("t1_inst1", inst, 16'h5678);
    chk("t1_pc1", inst_pc, 16'h0002);
    chk("t1_plus2_1", inst_pc_plus2, 16'h0004);

    // Slow memory and a stalled decoder; spurious acks while idle.
    do_reset(3, 1'b0);
    wait_valid(30, n);
    chk("t2_latency", n[15:0], 16'd5);
    chk("t2_inst", inst, 16'h1000);
    spur = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t2_stall_req", {15'd0, imem_req}, 16'h0000);
      chk("t2_stall_inst", inst, 16'h1000);
    end
    spur = 1'b0;
    inst_ready = 1'b1;
    @(negedge clk);
    wait_valid_pc(16'h0002, 30);
    chk("t2_inst2", inst, 16'h1002);

    // Redirect one cycle before the ack: in-flight word discarded.
    do_reset(3, 1'b1);
    wait_req(10);
    @(negedge clk);
    @(negedge clk);
    redirect = 1'b1;
    redirect_pc = 16'h0041;
    @(negedge clk);
    redirect = 1'b0;
    chk("t3_flush_addr", imem_addr, 16'h0000);
    @(negedge clk);
    chk("t3_new_addr", imem_addr, 16'h0040);
    wait_valid_pc(16'h0040, 30);
    chk("t3_inst", inst, 16'h1040);

    // HLT at 6 stops fetching for good.
    do_reset(0, 1'b1);
    mem[16'h0006] = 16'hF000;
    wait_valid_pc(16'h0006, 30);
    chk("t4_hlt_word", inst, 16'hF000);
    @(negedge clk);
    chk("t4_halted", {15'd0, halted}, 16'h0001);
    reqs = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (imem_req) reqs++;
    end
    chk("t4_req_count", reqs[15:0], 16'd0);
    redirect = 1'b1;
    redirect_pc = 16'h0100;
    @(negedge clk);
    redirect = 1'b0;
    repeat (3) @(negedge clk);
    chk("t4_still_halted", {15'd0, halted}, 16'h0001);
    chk("t4_no_req", {15'd0, imem_req}, 16'h0000);

    // HLT consumed together with a redirect: redirect wins.
    do_reset(0, 1'b1);
    mem[16'h0008] = 16'hF000;
    wait_valid_pc(16'h0008, 30);
    redirect = 1'b1;
    redirect_pc = 16'h0020;
    @(negedge clk);
    redirect = 1'b0;
    chk("t5_not_halted", {15'd0, halted}, 16'h0000);
    chk("t5_req", {15'd0, imem_req}, 16'h0001);
    chk("t5_addr", imem_addr, 16'h0020);
    wait_valid_pc(16'h0020, 20);
    chk("t5_inst", inst, 16'h1020);

    // PC wrap at the top of the address space.
    do_reset(0, 1'b1);
    wait_valid(20, n);
    redirect = 1'b1;
    redirect_pc = 16'hFFFE;
    @(negedge clk);
    redirect = 1'b0;
    wait_valid_pc(16'hFFFE, 20);
    chk("t6_inst", inst, 16'h1FFE);
    chk("t6_plus2", inst_pc_plus2, 16'h0000);
    @(negedge clk);
    chk("t6_wrap_addr", imem_addr, 16'h0000);

    // Reset in the middle of an outstanding read; late ack while idle.
    do_reset(5, 1'b1);
    wait_req(10);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t7_req", {15'd0, imem_req}, 16'h0000);
    chk("t7_addr", imem_addr, 16'h0000);
    chk("t7_valid", {15'd0, inst_valid}, 16'h0000);
    chk("t7_halted", {15'd0, halted}, 16'h0000);
    spur = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    spur = 1'b0;
    chk("t7_first_req", {15'd0, imem_req}, 16'h0001);
    chk("t7_first_addr", imem_addr, 16'h0000);
    chk("t7_valid_after", {15'd0, inst_valid}, 16'h0000);
    repeat (10) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : watchdog
    #500000;
    errors++;
    $display("FAIL watchdog: simulation did not finish at %0t", $time);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
